// File: rtl/sdram_pkg.sv
// Shared SDRAM controller definitions: command codes, address field layout,
// timing defaults and helpers used by the read/write/init modules.
package sdram_pkg;

    typedef logic [3:0] sdram_cmd_t;   // {cs_n, ras_n, cas_n, we_n}

    localparam sdram_cmd_t CMD_NOP   = 4'b0111;
    localparam sdram_cmd_t CMD_ACT   = 4'b0011;
    localparam sdram_cmd_t CMD_READ  = 4'b0101;
    localparam sdram_cmd_t CMD_WRITE = 4'b0100;
    localparam sdram_cmd_t CMD_BST   = 4'b0110;
    localparam sdram_cmd_t CMD_PREC  = 4'b0010;
    localparam sdram_cmd_t CMD_AREF  = 4'b0001;

    // Controller-side address: {bank[23:22], row[21:9], col[8:0]}
    typedef struct packed {
        logic [1:0]  bank;
        logic [12:0] row;
        logic [8:0]  col;
    } sdram_addr_t;

    localparam int TRCD_DEF    = 2;
    localparam int TRP_DEF     = 2;
    localparam int CAS_LAT_DEF = 3;

    localparam int MAX_BURST = 512;   // one full page

    localparam logic [12:0] PREC_ALL_ADDR = 13'h0400;   // A10=1 closes all banks
    localparam logic [12:0] IDLE_ADDR     = 13'h1fff;
    localparam logic [1:0]  IDLE_BANK     = 2'b11;

    // Requested length clamped into the range a single page burst can serve
    function automatic logic [9:0] clamp_burst(input logic [9:0] len);
        if (len == 10'd0)
            return 10'd1;
        if (len > 10'(MAX_BURST))
            return 10'(MAX_BURST);
        return len;
    endfunction

endpackage

// File: rtl/sdram_read.sv
// SDRAM read engine: ACT / READ / BST / PREC around one full-page burst,
// returning a qualified word stream. SDRAM_RD_STAT_EN builds the rd_ack word counter.
module sdram_read
    import sdram_pkg::*;
#(
    parameter int TRCD    = TRCD_DEF,
    parameter int TRP     = TRP_DEF,
    parameter int CAS_LAT = CAS_LAT_DEF
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        init_end,
    input  logic        rd_en,
    input  logic [23:0] rd_addr,
    input  logic [9:0]  rd_burst_len,
    input  logic [15:0] sdram_dq_in,
    output logic        rd_end,
    output logic        rd_ack,
    output logic [15:0] rd_data,
    output logic [3:0]  rd_sdram_cmd,
    output logic [1:0]  rd_sdram_bank,
    output logic [12:0] rd_sdram_addr,
    output logic [15:0] rd_word_cnt
);

    typedef enum logic [2:0] {
        RD_IDLE,
        RD_ACT,
        RD_TRCD,
        RD_READ,
        RD_DATA,
        RD_PREC,
        RD_TRP,
        RD_END
    } rd_state_e;

    // Wide enough for the longest RD_DATA span: MAX_BURST + CAS_LAT
    localparam int CNT_W = 10;

    rd_state_e          state_q, state_d;
    sdram_addr_t        addr_q, addr_d;
    logic [9:0]         len_q, len_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CAS_LAT-1:0] vld_pipe_q, vld_pipe_d;
    sdram_cmd_t         cmd_q, cmd_d;
    logic [1:0]         bank_q, bank_d;
    logic [12:0]        saddr_q, saddr_d;
    logic               ack_q, ack_d;
    logic [15:0]        data_q, data_d;
    logic               rd_win;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        cnt_d   = cnt_q + CNT_W'(1);
        cmd_d   = CMD_NOP;
        bank_d  = IDLE_BANK;
        saddr_d = IDLE_ADDR;
        rd_win  = 1'b0;

        unique case (state_q)
            RD_IDLE: begin
                cnt_d = '0;
                if (init_end && rd_en) begin
                    state_d = RD_ACT;
                    addr_d  = sdram_addr_t'(rd_addr);
                    len_d   = clamp_burst(rd_burst_len);
                end
            end
            RD_ACT: begin
                cmd_d   = CMD_ACT;
                bank_d  = addr_q.bank;
                saddr_d = addr_q.row;
                cnt_d   = '0;
                state_d = RD_TRCD;
            end
            RD_TRCD: begin
                if (cnt_q == CNT_W'(TRCD - 1)) begin
                    cnt_d   = '0;
                    state_d = RD_READ;
                end
            end
            RD_READ: begin
                cmd_d   = CMD_READ;
                bank_d  = addr_q.bank;
                saddr_d = {4'b0000, addr_q.col};
                cnt_d   = '0;
                state_d = RD_DATA;
            end
            RD_DATA: begin
                // cnt_q==0 is the cycle READ sits on the bus; the device wraps
                // the column inside the open page, so no extra READs are needed.
                rd_win = (cnt_q < len_q);
                if (cnt_q == len_q - CNT_W'(1))
                    cmd_d = CMD_BST;
                if (cnt_q == len_q + CNT_W'(CAS_LAT - 1)) begin
                    cnt_d   = '0;
                    state_d = RD_PREC;
                end
            end
            RD_PREC: begin
                cmd_d   = CMD_PREC;
                bank_d  = addr_q.bank;
                saddr_d = PREC_ALL_ADDR;
                cnt_d   = '0;
                state_d = RD_TRP;
            end
            RD_TRP: begin
                if (cnt_q == CNT_W'(TRP - 1)) begin
                    cnt_d   = '0;
                    state_d = RD_END;
                end
            end
            RD_END: begin
                cnt_d   = '0;
                state_d = RD_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = RD_IDLE;
            end
        endcase

        // The read window delayed by CAS latency marks which DQ cycles carry data
        vld_pipe_d = CAS_LAT'({vld_pipe_q, rd_win});
        ack_d      = vld_pipe_q[CAS_LAT-1];
        data_d     = ack_d ? sdram_dq_in : data_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= RD_IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            vld_pipe_q <= '0;
            cmd_q      <= CMD_NOP;
            bank_q     <= IDLE_BANK;
            saddr_q    <= IDLE_ADDR;
            ack_q      <= 1'b0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            vld_pipe_q <= vld_pipe_d;
            cmd_q      <= cmd_d;
            bank_q     <= bank_d;
            saddr_q    <= saddr_d;
            ack_q      <= ack_d;
            data_q     <= data_d;
        end
    end

    assign rd_sdram_cmd  = cmd_q;
    assign rd_sdram_bank = bank_q;
    assign rd_sdram_addr = saddr_q;
    assign rd_ack        = ack_q;
    assign rd_data       = data_q;
    assign rd_end        = (state_q == RD_END);

`ifdef SDRAM_RD_STAT_EN
    logic [15:0] word_cnt_q, word_cnt_d;

    // Counts alongside rd_ack so the total is visible in the same cycle
    always_comb word_cnt_d = word_cnt_q + 16'(ack_d);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            word_cnt_q <= '0;
        else
            word_cnt_q <= word_cnt_d;
    end

    assign rd_word_cnt = word_cnt_q;
`else
    assign rd_word_cnt = 16'd0;
`endif

endmodule
